// File: rtl/freq_calc_pkg.sv
// Shared types and constants for the frequency calculator.
// Both Multiplier and Freq use the same packed layout. Each 32-bit word holds
// two 16-bit halves, and each half is {whole[8:0], hundredths[6:0]}.
// No ports: this file is a package.
package freq_calc_pkg;

    localparam int WHOLE_W        = 9;
    localparam int DEC_W          = 7;
    localparam int MAX_HUNDREDTHS = 51199;

    typedef struct packed {
        logic [WHOLE_W-1:0] whole;
        logic [DEC_W-1:0]   dec;
    } half_t;

    // 511.99, the largest value a half can represent
    localparam half_t SAT_HALF = 16'hFFE3;

    typedef enum logic [2:0] {IDLE, LOAD, DIV_LO, DIV_HI, PACK} fc_state_t;

    // Split a value in hundredths into whole and hundredths fields.
    // The caller guarantees q <= MAX_HUNDREDTHS.
    function automatic half_t to_half(input logic [15:0] q);
        half_t h;
        h.whole = WHOLE_W'(q / 16'd100);
        h.dec   = DEC_W'(q % 16'd100);
        return h;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Fixed-latency restoring divider. It produces one quotient bit per enabled
// clock.
// Ports: Clk, Reset (sync, active-high), En (freeze when low),
//        Go   (start; the first step uses Num on this same edge),
//        Num/Den (operands), Quo (quotient, held after completion),
//        Done (one-cycle pulse after the W-th step; held while En is low).
// Go may be asserted in the Done cycle to start back-to-back divisions.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         En,
    input  logic         Go,
    input  logic [W-1:0] Num,
    input  logic [W-1:0] Den,
    output logic [W-1:0] Quo,
    output logic         Done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem, rem_in, quo_in, rem_nx, quo_nx;
    logic [W:0]    trial;
    logic [CW-1:0] cnt;

    // One restoring step. Quo doubles as the shift register for the dividend.
    always_comb begin
        rem_in = Go ? '0  : rem;
        quo_in = Go ? Num : Quo;
        trial  = {rem_in, quo_in[W-1]} - {1'b0, Den};
        if (!trial[W]) begin
            rem_nx = trial[W-1:0];
            quo_nx = {quo_in[W-2:0], 1'b1};
        end else begin
            rem_nx = {rem_in[W-2:0], quo_in[W-1]};
            quo_nx = {quo_in[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rem  <= '0;
            Quo  <= '0;
            cnt  <= '0;
            Done <= 1'b0;
        end else if (En) begin
            Done <= 1'b0;
            if (Go) begin
                rem  <= rem_nx;
                Quo  <= quo_nx;
                cnt  <= CW'(W - 1);
                Done <= (W == 1);
            end else if (cnt != '0) begin
                rem  <= rem_nx;
                Quo  <= quo_nx;
                cnt  <= cnt - 1'b1;
                Done <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: rtl/frequency_calculator.sv
// Converts a packed ADPLL multiplier word back into the output frequency it
// produces. The result uses the same two-half packed MHz format:
//   freq_h = M_h * 100 * C_CRYSTAL / Ratio_Crystal  (in hundredths of MHz).
// Latency is a fixed 66 clocks from the Start edge to the Done edge. One
// shared sequential divider is used, first for the low half and then for the
// high half.
// Ports: Clk, Reset (sync, active-high), En (freeze when low), Start,
//        Ratio_Crystal (hundredths), Multiplier (packed), Freq (packed),
//        Busy, Done (pulse), Sat, Err (valid with Done, held until Start).
// Build option: define FREQ_CALC_ROUND_EN for round-half-up. By default the
// division truncates.
module frequency_calculator
    import freq_calc_pkg::*;
#(
    parameter int C_CRYSTAL = 50,
    parameter int DIV_W     = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic        Start,
    input  logic [31:0] Ratio_Crystal,
    input  logic [31:0] Multiplier,
    output logic [31:0] Freq,
    output logic        Busy,
    output logic        Done,
    output logic        Sat,
    output logic        Err
);

    fc_state_t        state, state_nx;
    logic [31:0]      ratio_r, mult_r;
    logic [DIV_W-1:0] num_lo, num_hi, div_num, div_den, div_quo, q_lo;
    logic             div_go, div_done, ratio_zero, dec_err, sat_lo, sat_hi;
    half_t            in_lo, in_hi, out_lo, out_hi;

    // Scaled numerator for one half. Out-of-range hundredths are clamped to 99.
    function automatic logic [DIV_W-1:0] scaled(input half_t h);
        logic [DIV_W-1:0] dec, m;
        dec = (h.dec > DEC_W'(99)) ? DIV_W'(99) : DIV_W'(h.dec);
        m   = DIV_W'(h.whole) * DIV_W'(100) + dec;
        return m * DIV_W'(100 * C_CRYSTAL);
    endfunction

    assign in_lo      = half_t'(mult_r[15:0]);
    assign in_hi      = half_t'(mult_r[31:16]);
    assign ratio_zero = (ratio_r == '0);
    assign dec_err    = (in_lo.dec > DEC_W'(99)) || (in_hi.dec > DEC_W'(99));
    assign div_den    = DIV_W'(ratio_r);
    assign Busy       = (state != IDLE);

    always_comb begin
        num_lo = scaled(in_lo);
        num_hi = scaled(in_hi);
`ifdef FREQ_CALC_ROUND_EN
        num_lo = num_lo + DIV_W'(ratio_r >> 1);
        num_hi = num_hi + DIV_W'(ratio_r >> 1);
`endif
    end

    // The divider takes its first step on the Go edge. LOAD therefore issues
    // Go, and the high half is issued in the same cycle that the low result
    // becomes valid. This keeps the Start-to-Done latency at exactly 66 clocks.
    always_comb begin
        state_nx = state;
        div_go   = 1'b0;
        div_num  = num_hi;
        unique case (state)
            IDLE:   if (Start) state_nx = LOAD;
            LOAD: begin
                div_go   = 1'b1;
                div_num  = num_lo;
                state_nx = DIV_LO;
            end
            DIV_LO: if (div_done) begin
                div_go   = 1'b1;
                state_nx = DIV_HI;
            end
            DIV_HI: if (div_done) state_nx = PACK;
            PACK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset)   state <= IDLE;
        else if (En) state <= state_nx;
    end

    seq_divider #(.W(DIV_W)) u_div (
        .Clk  (Clk),
        .Reset(Reset),
        .En   (En),
        .Go   (div_go),
        .Num  (div_num),
        .Den  (div_den),
        .Quo  (div_quo),
        .Done (div_done)
    );

    // In PACK the divider still holds the high-half quotient.
    always_comb begin
        sat_lo = (q_lo    > DIV_W'(MAX_HUNDREDTHS));
        sat_hi = (div_quo > DIV_W'(MAX_HUNDREDTHS));
        out_lo = (ratio_zero || sat_lo) ? SAT_HALF : to_half(q_lo[15:0]);
        out_hi = (ratio_zero || sat_hi) ? SAT_HALF : to_half(div_quo[15:0]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ratio_r <= '0;
            mult_r  <= '0;
            q_lo    <= '0;
            Freq    <= '0;
            Done    <= 1'b0;
            Sat     <= 1'b0;
            Err     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (En) begin
                unique case (state)
                    IDLE: if (Start) begin
                        ratio_r <= Ratio_Crystal;
                        mult_r  <= Multiplier;
                        Sat     <= 1'b0;
                        Err     <= 1'b0;
                    end
                    LOAD:   Err <= ratio_zero || dec_err;
                    DIV_LO: if (div_done) q_lo <= div_quo;
                    PACK: begin
                        Freq <= {out_hi, out_lo};
                        Sat  <= sat_lo || sat_hi || ratio_zero;
                        Done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
